// File: rtl/dfr_ctrl_pkg.sv
// Shared encodings for the DFR batch controller: FSM states, run modes, error codes.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package dfr_ctrl_pkg;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_RES_RUN  = 3'd2;
  localparam logic [2:0] ST_MM_START = 3'd3;
  localparam logic [2:0] ST_MM_RUN   = 3'd4;
  localparam logic [2:0] ST_NEXT     = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [1:0] {
    MODE_FULL         = 2'b00,
    MODE_RES_ONLY     = 2'b01,
    MODE_READOUT_ONLY = 2'b10,
    MODE_RESERVED     = 2'b11
  } mode_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RES_TMO  = 2'b01;
  localparam logic [1:0] ERR_MM_TMO   = 2'b10;
  localparam logic [1:0] ERR_BAD_MODE = 2'b11;

endpackage

// File: rtl/dfr_stage_watchdog.sv
// Per-stage busy handshake tracker and timeout watchdog for one engine at a time.
// Latency: complete/timeout are combinational on busy and the registered count/seen.
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst_n; clear (reset count/seen), enable (stage active), busy (muxed engine busy);
//        seen (busy observed high this stage), complete (seen and busy low), timeout.
module dfr_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic busy,
  output logic seen,
  output logic complete,
  output logic timeout
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             seen_q, seen_d;

  // Saturating: the counter parks at TIMEOUT_CYCLES and never wraps.
  assign cnt_inc = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + TMO_W'(1);

  always_comb begin
    cnt_d  = cnt_q;
    seen_d = seen_q;
    if (clear) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (enable) begin
      cnt_d = cnt_inc;
      if (busy) seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
    end
  end

  assign seen     = seen_q;
  assign complete = enable && seen_q && !busy;
  // The count reaches TIMEOUT_CYCLES at the end of this cycle, so the stage
  // has occupied exactly TIMEOUT_CYCLES cycles when this fires.
  assign timeout  = enable && (cnt_inc == TMO_MAX);

endmodule

// File: rtl/dfr_batch_controller.sv
// Sequences a batch of samples through the reservoir and matrix-multiply engines.
// Latency: start -> INIT next cycle, first stage the cycle after; Moore outputs except abort resets.
// Backpressure: start ignored outside IDLE; abort returns to IDLE next edge from any active state.
// Ports: clk, rst_n; start/abort/mode/num_samples from registers; engine busy inputs;
//        engine reset/enable/start outputs; busy, sample_idx, dfr_done, error, error_code.
module dfr_batch_controller
  import dfr_ctrl_pkg::*;
#(
  parameter int SAMPLE_W       = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic [SAMPLE_W-1:0] num_samples,
  input  logic                reservoir_busy,
  input  logic                matrix_multiply_busy,
  output logic                busy,
  output logic                reservoir_rst,
  output logic                matrix_multiply_rst,
  output logic                reservoir_en,
  output logic                reservoir_history_en,
  output logic                matrix_multiply_start,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic                dfr_done,
  output logic                error,
  output logic [1:0]          error_code
);

  logic [2:0]          state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [SAMPLE_W-1:0] num_q, num_d;
  logic [SAMPLE_W-1:0] idx_q, idx_d;
  logic [1:0]          code_q, code_d;

  logic in_stage, abort_hit, stage_busy;
  logic wd_seen, wd_complete, wd_timeout, stage_done;

  assign in_stage   = (state_q == ST_RES_RUN) || (state_q == ST_MM_RUN);
  assign abort_hit  = abort && (state_q != ST_IDLE);
  assign stage_busy = (state_q == ST_MM_RUN) ? matrix_multiply_busy : reservoir_busy;

  // Stages are only ever entered from a non-stage state, so holding the
  // watchdog clear outside the stages clears it on every stage entry.
  dfr_stage_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMO_W          (TMO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!in_stage),
    .enable   (in_stage),
    .busy     (stage_busy),
    .seen     (wd_seen),
    .complete (wd_complete),
    .timeout  (wd_timeout)
  );

  assign stage_done = wd_seen && wd_complete;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    num_d   = num_q;
    idx_d   = idx_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          num_d  = num_samples;
          idx_d  = '0;
          if (mode == MODE_RESERVED) begin
            code_d = ERR_BAD_MODE;
          end else begin
            code_d  = ERR_NONE;
            state_d = ST_INIT;
          end
        end
      end
      ST_INIT: begin
        if (num_q == '0)                      state_d = ST_DONE;
        else if (mode_q == MODE_READOUT_ONLY) state_d = ST_MM_START;
        else                                  state_d = ST_RES_RUN;
      end
      ST_RES_RUN: begin
        if (wd_timeout) begin
          state_d = ST_IDLE;
          code_d  = ERR_RES_TMO;
        end else if (stage_done) begin
          state_d = (mode_q == MODE_FULL) ? ST_MM_START : ST_NEXT;
        end
      end
      ST_MM_START: state_d = ST_MM_RUN;
      ST_MM_RUN: begin
        if (wd_timeout) begin
          state_d = ST_IDLE;
          code_d  = ERR_MM_TMO;
        end else if (stage_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Compare before incrementing so the last index of a full-range batch never wraps.
        if (idx_q == num_q - SAMPLE_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + SAMPLE_W'(1);
          state_d = (mode_q == MODE_READOUT_ONLY) ? ST_MM_START : ST_RES_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort beats timeout and completion: error and index are left untouched.
    if (abort_hit) begin
      state_d = ST_IDLE;
      code_d  = code_q;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
    end
  end

  assign busy                  = (state_q != ST_IDLE);
  assign reservoir_rst         = (state_q == ST_INIT) || abort_hit;
  assign matrix_multiply_rst   = (state_q == ST_INIT) || abort_hit;
  assign reservoir_en          = (state_q == ST_RES_RUN);
  assign reservoir_history_en  = (state_q == ST_RES_RUN);
  assign matrix_multiply_start = (state_q == ST_MM_START);
  assign dfr_done              = (state_q == ST_DONE);
  assign sample_idx            = idx_q;
  assign error_code            = code_q;
  assign error                 = (code_q != ERR_NONE);

endmodule
